bpi_bus_engine: RTL

BPI_BUS_ENGINE -- requirements
Module: bpi_bus_engine

---
 rtl/bpi_pkg.sv | 30 +++
 rtl/bpi_phase_timer.sv | 27 ++
 rtl/bpi_bus_engine.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bpi_pkg.sv
// Shared constants for the BPI flash bus engine: op codes, FSM state encoding,
// default phase timings and the phase-timer width.
package bpi_pkg;

  localparam logic [1:0] OP_NOP     = 2'd0;
  localparam logic [1:0] OP_WRITE   = 2'd1;
  localparam logic [1:0] OP_READ    = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_POLL   = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  localparam int          DEF_SETUP_CYC = 2;
  localparam int          DEF_RD_CYC    = 4;
  localparam int          DEF_WE_CYC    = 3;
  localparam int          DEF_HOLD_CYC  = 1;
  localparam logic [15:0] DEF_POLL_MAX  = 16'd1000;

  localparam int TMR_W = 16;

  // Phase lengths are integer parameters; the timer only loads TMR_W bits.
  function automatic logic [TMR_W-1:0] cyc16(input int n);
    return n[TMR_W-1:0];
  endfunction

endpackage

// File: rtl/bpi_phase_timer.sv
// Loadable down-counter timing one bus phase; done is high on the last cycle
// of a phase loaded with N (N >= 1) cycles.
module bpi_phase_timer
  import bpi_pkg::*;
(
  input  logic             drck,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge drck or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == {{(TMR_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/bpi_bus_engine.sv
// Asynchronous BPI flash bus engine driven by a JTAG-side command port.
// Optional write-status polling is compiled in with `define BPI_STATUS_POLL_EN.
module bpi_bus_engine
  import bpi_pkg::*;
#(
  parameter int          SETUP_CYC = DEF_SETUP_CYC,
  parameter int          RD_CYC    = DEF_RD_CYC,
  parameter int          WE_CYC    = DEF_WE_CYC,
  parameter int          HOLD_CYC  = DEF_HOLD_CYC,
  parameter logic [15:0] POLL_MAX  = DEF_POLL_MAX
) (
  input  logic        drck,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [24:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [25:1] bpi_addr,
  output logic [15:0] bpi_dq_o,
  output logic        bpi_dq_oe,
  input  logic [15:0] bpi_dq_i,
  output logic        bpi_ce_n,
  output logic        bpi_oe_n,
  output logic        bpi_we_n,
  output logic        bpi_adv_n
);

  logic [2:0]       state, state_nxt;
  logic [1:0]       op_q, op_nxt;
  logic [24:0]      addr_q, addr_nxt;
  logic [15:0]      wdata_q, wdata_nxt;
  logic             tmr_load, tmr_done;
  logic [TMR_W-1:0] tmr_val;
  logic             err_nxt, sample, clear_rdata;
  logic             in_access, in_data, oe_low_nxt;

`ifdef BPI_STATUS_POLL_EN
  logic        poll_gap, poll_gap_nxt;
  logic [15:0] poll_cnt, poll_cnt_nxt;
`endif

  bpi_phase_timer u_timer (
    .drck     (drck),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_nxt   = state;
    op_nxt      = op_q;
    addr_nxt    = addr_q;
    wdata_nxt   = wdata_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    err_nxt     = 1'b0;
    sample      = 1'b0;
    clear_rdata = 1'b0;
`ifdef BPI_STATUS_POLL_EN
    poll_gap_nxt = poll_gap;
    poll_cnt_nxt = poll_cnt;
`endif
    case (state)
      ST_IDLE: if (cmd_valid && cmd_ready) begin
        op_nxt    = cmd_op;
        addr_nxt  = cmd_addr;
        wdata_nxt = cmd_wdata;
        case (cmd_op)
          OP_NOP: begin
            state_nxt   = ST_RESP;
            clear_rdata = 1'b1;
          end
          OP_WRITE, OP_READ: begin
            state_nxt = ST_SETUP;
            tmr_load  = 1'b1;
            tmr_val   = cyc16(SETUP_CYC);
          end
          default: begin
            state_nxt = ST_RESP;
            err_nxt   = 1'b1;
          end
        endcase
      end
      ST_SETUP: if (tmr_done) begin
        state_nxt = ST_STROBE;
        tmr_load  = 1'b1;
        tmr_val   = (op_q == OP_READ) ? cyc16(RD_CYC) : cyc16(WE_CYC);
      end
      ST_STROBE: if (tmr_done) begin
        sample    = (op_q == OP_READ);
        state_nxt = ST_HOLD;
        tmr_load  = 1'b1;
        tmr_val   = cyc16(HOLD_CYC);
      end
      ST_HOLD: if (tmr_done) begin
`ifdef BPI_STATUS_POLL_EN
        if (op_q == OP_WRITE) begin
          state_nxt    = ST_POLL;
          tmr_load     = 1'b1;
          tmr_val      = cyc16(RD_CYC);
          poll_gap_nxt = 1'b0;
          poll_cnt_nxt = '0;
        end else begin
          state_nxt = ST_RESP;
        end
`else
        state_nxt = ST_RESP;
`endif
      end
`ifdef BPI_STATUS_POLL_EN
      // Each poll is an OE-low read window followed by a one-cycle OE-high gap.
      ST_POLL: if (tmr_done) begin
        if (!poll_gap) begin
          sample       = 1'b1;
          poll_cnt_nxt = poll_cnt + 16'd1;
          if (bpi_dq_i[7]) begin
            state_nxt = ST_RESP;
          end else if (poll_cnt_nxt >= POLL_MAX) begin
            state_nxt = ST_RESP;
            err_nxt   = 1'b1;
          end else begin
            poll_gap_nxt = 1'b1;
            tmr_load     = 1'b1;
            tmr_val      = cyc16(1);
          end
        end else begin
          poll_gap_nxt = 1'b0;
          tmr_load     = 1'b1;
          tmr_val      = cyc16(RD_CYC);
        end
      end
`endif
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus pins are registered from the next state so they change with it.
  assign in_access = (state_nxt == ST_SETUP) || (state_nxt == ST_STROBE) ||
                     (state_nxt == ST_HOLD)  || (state_nxt == ST_POLL);
  assign in_data   = (op_nxt == OP_WRITE) &&
                     ((state_nxt == ST_SETUP) || (state_nxt == ST_STROBE) || (state_nxt == ST_HOLD));
`ifdef BPI_STATUS_POLL_EN
  assign oe_low_nxt = ((state_nxt == ST_STROBE) && (op_nxt == OP_READ)) ||
                      ((state_nxt == ST_POLL) && !poll_gap_nxt);
`else
  assign oe_low_nxt = (state_nxt == ST_STROBE) && (op_nxt == OP_READ);
`endif

  always_ff @(posedge drck or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_NOP;
      addr_q    <= '0;
      wdata_q   <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      bpi_addr  <= '0;
      bpi_dq_o  <= '0;
      bpi_dq_oe <= 1'b0;
      bpi_ce_n  <= 1'b1;
      bpi_oe_n  <= 1'b1;
      bpi_we_n  <= 1'b1;
      bpi_adv_n <= 1'b1;
    end else begin
      state     <= state_nxt;
      op_q      <= op_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      cmd_ready <= (state_nxt == ST_IDLE);
      rsp_valid <= (state_nxt == ST_RESP);
      rsp_err   <= err_nxt;
      bpi_ce_n  <= !in_access;
      bpi_adv_n <= (state_nxt != ST_SETUP);
      bpi_oe_n  <= !oe_low_nxt;
      bpi_we_n  <= !((state_nxt == ST_STROBE) && (op_nxt == OP_WRITE));
      bpi_dq_oe <= in_data;
      if (in_access) bpi_addr <= addr_nxt;
      if (in_data) bpi_dq_o <= wdata_nxt;
      if (clear_rdata) begin
        rsp_rdata <= '0;
      end else if (sample) begin
        rsp_rdata <= bpi_dq_i;
      end
    end
  end

`ifdef BPI_STATUS_POLL_EN
  always_ff @(posedge drck or negedge rst_n) begin
    if (!rst_n) begin
      poll_gap <= 1'b0;
      poll_cnt <= '0;
    end else begin
      poll_gap <= poll_gap_nxt;
      poll_cnt <= poll_cnt_nxt;
    end
  end
`endif

endmodule
